dis_pal_pattern_gen: RTL and testbench

- Avalon-ST Video test-pattern source sitting directly upstream of the PAL display top; its dout_* bus connects to the display top's vst_* stream input.
- Each frame is emitted as one control packet (type 0xF: width, height, interlace) followed by one video packet (type 0x0) carrying IM_WIDTH x IM_HEIGHT single-plane pixels.
- Used for bring-up and board test of the PAL output path without a camera or frame buffer.

---
 rtl/dis_pal_pattern_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_dis_pal_pattern_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dis_pal_pattern_gen.sv
// dis_pal_pattern_gen
//   Avalon-ST Video test-pattern source for the PAL display path. Each frame
//   is one control packet (type 0xF: width, height, interlace nibbles)
//   followed by one video packet (type 0x0) of IM_WIDTH x IM_HEIGHT pixels.
// Ports:
//   clk, rst             stream clock, synchronous active-high reset
//   enable               level; a new frame starts only while high
//   mode                 0 flat, 1 ramp, 2 vertical bars, 3 checkerboard
//   flat_value           mode-0 pixel value
//   dout_*               Avalon-ST source (ready latency 0), all registered
//   frame_done           one-cycle pulse after the last video beat transfers
module dis_pal_pattern_gen #(
  parameter int          DATA_WIDTH    = 10,
  parameter logic [15:0] IM_WIDTH      = 16'd720,
  parameter logic [15:0] IM_HEIGHT     = 16'd576,
  parameter logic [3:0]  IM_INTERLACED = 4'h0,
  parameter logic [9:0]  BAR_WIDTH     = 10'd90,
  parameter logic [3:0]  RAMP_STEP     = 4'd1,
  parameter logic [15:0] FRAME_GAP     = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] flat_value,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL_HDR, S_CTRL_BODY, S_VID_HDR, S_VID_DATA, S_GAP
  } state_t;

  // State names the beat currently held in the output register.
  state_t                r_state, w_state_nxt;
  logic [1:0]            r_mode, w_mode_nxt;
  logic [DATA_WIDTH-1:0] r_flat, w_flat_nxt;
  logic [3:0]            r_nib, w_nib_nxt;
  logic [15:0]           r_x, w_x_nxt;
  logic [15:0]           r_y, w_y_nxt;
  logic [9:0]            r_bar_cnt, w_bar_cnt_nxt;
  logic [2:0]            r_bar_idx, w_bar_idx_nxt;
  logic [15:0]           r_gap, w_gap_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_sop, w_sop_nxt;
  logic                  r_eop, w_eop_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_xfer;
  logic                  w_last;

  function automatic logic [3:0] f_ctrl_nib(input logic [3:0] n);
    case (n)
      4'd0:    f_ctrl_nib = IM_WIDTH[15:12];
      4'd1:    f_ctrl_nib = IM_WIDTH[11:8];
      4'd2:    f_ctrl_nib = IM_WIDTH[7:4];
      4'd3:    f_ctrl_nib = IM_WIDTH[3:0];
      4'd4:    f_ctrl_nib = IM_HEIGHT[15:12];
      4'd5:    f_ctrl_nib = IM_HEIGHT[11:8];
      4'd6:    f_ctrl_nib = IM_HEIGHT[7:4];
      4'd7:    f_ctrl_nib = IM_HEIGHT[3:0];
      4'd8:    f_ctrl_nib = IM_INTERLACED;
      default: f_ctrl_nib = 4'h0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_pixel(
    input logic [1:0]            m,
    input logic [DATA_WIDTH-1:0] flat,
    input logic [15:0]           x,
    input logic                  y6,
    input logic [2:0]            bidx
  );
    case (m)
      2'd0:    f_pixel = flat;
      2'd1:    f_pixel = DATA_WIDTH'(x) * DATA_WIDTH'(RAMP_STEP);
      2'd2:    f_pixel = DATA_WIDTH'(bidx) << (DATA_WIDTH - 3);
      default: f_pixel = (x[6] ^ y6) ? '1 : '0;
    endcase
  endfunction

  assign w_xfer = r_valid & dout_ready;
  assign w_last = (r_x == IM_WIDTH - 16'd1) && (r_y == IM_HEIGHT - 16'd1);

  // Next beat is prepared when the held beat transfers (or none is held),
  // so the output register only changes after a handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_flat_nxt    = r_flat;
    w_nib_nxt     = r_nib;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_bar_cnt_nxt = r_bar_cnt;
    w_bar_idx_nxt = r_bar_idx;
    w_gap_nxt     = r_gap;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_sop_nxt     = r_sop;
    w_eop_nxt     = r_eop;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_mode_nxt  = mode;
          w_flat_nxt  = flat_value;
          w_data_nxt  = DATA_WIDTH'(4'hF);
          w_valid_nxt = 1'b1;
          w_sop_nxt   = 1'b1;
          w_eop_nxt   = 1'b0;
          w_state_nxt = S_CTRL_HDR;
        end
      end
      S_CTRL_HDR: begin
        if (w_xfer) begin
          w_nib_nxt   = 4'd0;
          w_data_nxt  = DATA_WIDTH'(f_ctrl_nib(4'd0));
          w_sop_nxt   = 1'b0;
          w_eop_nxt   = 1'b0;
          w_state_nxt = S_CTRL_BODY;
        end
      end
      S_CTRL_BODY: begin
        if (w_xfer) begin
          if (r_nib == 4'd8) begin
            w_data_nxt  = '0;
            w_sop_nxt   = 1'b1;
            w_eop_nxt   = 1'b0;
            w_state_nxt = S_VID_HDR;
          end else begin
            w_nib_nxt  = r_nib + 4'd1;
            w_data_nxt = DATA_WIDTH'(f_ctrl_nib(r_nib + 4'd1));
            w_eop_nxt  = (r_nib == 4'd7);
          end
        end
      end
      S_VID_HDR: begin
        if (w_xfer) begin
          w_x_nxt       = '0;
          w_y_nxt       = '0;
          w_bar_cnt_nxt = '0;
          w_bar_idx_nxt = '0;
          w_data_nxt    = f_pixel(r_mode, r_flat, 16'd0, 1'b0, 3'd0);
          w_sop_nxt     = 1'b0;
          w_eop_nxt     = (IM_WIDTH == 16'd1) && (IM_HEIGHT == 16'd1);
          w_state_nxt   = S_VID_DATA;
        end
      end
      S_VID_DATA: begin
        if (w_xfer) begin
          if (w_last) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_eop_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = FRAME_GAP - 16'd1;
            w_state_nxt = (FRAME_GAP == 16'd0) ? S_IDLE : S_GAP;
          end else begin
            if (r_x == IM_WIDTH - 16'd1) begin
              w_x_nxt       = '0;
              w_y_nxt       = r_y + 16'd1;
              w_bar_cnt_nxt = '0;
              w_bar_idx_nxt = '0;
            end else begin
              w_x_nxt = r_x + 16'd1;
              if (r_bar_cnt == BAR_WIDTH - 10'd1) begin
                w_bar_cnt_nxt = '0;
                w_bar_idx_nxt = r_bar_idx + 3'd1;
              end else begin
                w_bar_cnt_nxt = r_bar_cnt + 10'd1;
              end
            end
            w_data_nxt = f_pixel(r_mode, r_flat, w_x_nxt, w_y_nxt[6], w_bar_idx_nxt);
            w_eop_nxt  = (w_x_nxt == IM_WIDTH - 16'd1) && (w_y_nxt == IM_HEIGHT - 16'd1);
          end
        end
      end
      S_GAP: begin
        if (r_gap == 16'd0) w_state_nxt = S_IDLE;
        else                w_gap_nxt   = r_gap - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_flat    <= '0;
      r_nib     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_gap     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_flat    <= w_flat_nxt;
      r_nib     <= w_nib_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_bar_cnt <= w_bar_cnt_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_gap     <= w_gap_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_sop     <= w_sop_nxt;
      r_eop     <= w_eop_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign dout_data          = r_data;
  assign dout_valid         = r_valid;
  assign dout_startofpacket = r_sop;
  assign dout_endofpacket   = r_eop;
  assign frame_done         = r_done;

endmodule

// File: tb/tb_dis_pal_pattern_gen.sv
// tb_dis_pal_pattern_gen
//   Randomized self-checking bench for dis_pal_pattern_gen, using a reduced
//   frame size so checkerboard, bar wrap and ramp wrap all occur.
module tb_dis_pal_pattern_gen;

  localparam int          DW   = 8;
  localparam logic [15:0] W    = 16'd72;
  localparam logic [15:0] H    = 16'd66;
  localparam logic [3:0]  ILC  = 4'h3;
  localparam logic [9:0]  BAR  = 10'd8;
  localparam logic [3:0]  STEP = 4'd5;
  localparam logic [15:0] GAP  = 16'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] flat_value = '0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_startofpacket;
  logic          dout_endofpacket;
  logic          frame_done;

  dis_pal_pattern_gen #(
    .DATA_WIDTH(DW), .IM_WIDTH(W), .IM_HEIGHT(H), .IM_INTERLACED(ILC),
    .BAR_WIDTH(BAR), .RAMP_STEP(STEP), .FRAME_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .flat_value(flat_value),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat encoding: {sop, eop, data}
  logic [DW+1:0] rx[$];
  logic [DW+1:0] ex[$];

  function automatic int ref_pixel(input int m, input int flat, input int x, input int y);
    case (m)
      0:       return flat;
      1:       return (x * int'(STEP)) % 256;
      2:       return ((x / int'(BAR)) % 8) * 32;
      default: return ((((x / 64) + (y / 64)) % 2) == 1) ? 255 : 0;
    endcase
  endfunction

  task automatic build_frame(input int m, input int flat);
    ex.push_back({1'b1, 1'b0, DW'(8'h0F)});
    for (int i = 0; i < 9; i++) begin
      int nib;
      if (i < 4)      nib = (int'(W) >> (12 - 4 * i)) % 16;
      else if (i < 8) nib = (int'(H) >> (28 - 4 * i)) % 16;
      else            nib = int'(ILC);
      ex.push_back({1'b0, (i == 8), DW'(nib)});
    end
    ex.push_back({1'b1, 1'b0, DW'(0)});
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        ex.push_back({1'b0, (x == int'(W) - 1 && y == int'(H) - 1),
                      DW'(ref_pixel(m, flat, x, y))});
  endtask

  // Ready generator: always-ready or ~50% random.
  logic rand_rdy = 1'b0;
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: collects transfers, checks stall stability and frame_done timing.
  int unsigned   cyc = 0;
  int            ndone = 0;
  int            gap_seen = -1;
  int unsigned   last_eop = 0;
  logic          in_vid = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_vid_eop = 1'b0;
  logic [DW+1:0] prev_beat = '0;
  logic [DW+1:0] beat;

  always @(negedge clk) begin
    cyc++;
    beat = {dout_startofpacket, dout_endofpacket, dout_data};
    if (prev_stall) begin
      check("hold_valid", 32'(dout_valid), 32'd1);
      check("hold_beat", 32'(beat), 32'(prev_beat));
    end
    if (frame_done) ndone++;
    if (frame_done || prev_vid_eop) check("done_timing", 32'(frame_done), 32'(prev_vid_eop));
    prev_vid_eop = 1'b0;
    if (!rst && dout_valid && dout_ready) begin
      rx.push_back(beat);
      if (dout_startofpacket) begin
        in_vid = (dout_data[3:0] == 4'h0);
        if (dout_data[3:0] == 4'hF) gap_seen = int'(cyc - last_eop);
      end
      if (dout_endofpacket && in_vid) begin
        prev_vid_eop = 1'b1;
        last_eop     = cyc;
      end
    end
    prev_stall = !rst && dout_valid && !dout_ready;
    prev_beat  = beat;
  end

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (rx.size() < n) check("timeout_rx", 32'(rx.size()), 32'(n));
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (ndone < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (ndone < n) check("timeout_done", 32'(ndone), 32'(n));
  endtask

  task automatic compare_stream(input string tag);
    int nmis = 0;
    check({tag, "_len"}, 32'(rx.size()), 32'(ex.size()));
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      if (rx[i] !== ex[i]) begin
        if (nmis == 0) check({tag, "_first_bad_beat"}, 32'(rx[i]), 32'(ex[i]));
        nmis++;
      end
    end
    check({tag, "_mismatches"}, 32'(nmis), 32'd0);
  endtask

  // One frame; enable drops and mode/flat are scrambled once video has begun.
  task automatic run_frame(input string tag, input logic [1:0] m, input logic [DW-1:0] flat,
                           input logic rr);
    rx.delete();
    ex.delete();
    ndone = 0;
    build_frame(int'(m), int'(flat));
    @(posedge clk);
    #1;
    rand_rdy   = rr;
    mode       = m;
    flat_value = flat;
    enable     = 1'b1;
    wait_rx(20, 200);
    enable     = 1'b0;
    mode       = m + 2'd1;
    flat_value = ~flat;
    wait_done(1, 20000);
    repeat (int'(GAP) + 6) @(posedge clk);
    #1;
    rand_rdy = 1'b0;
    compare_stream(tag);
    check({tag, "_done_cnt"}, 32'(ndone), 32'd1);
    check({tag, "_idle_valid"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_data", 32'(dout_data), 32'd0);
    check("rst_sop", 32'(dout_startofpacket), 32'd0);
    check("rst_eop", 32'(dout_endofpacket), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    run_frame("flat", 2'd0, DW'($urandom), 1'b0);
    run_frame("ramp", 2'd1, DW'($urandom), 1'b0);
    run_frame("bars", 2'd2, DW'($urandom), 1'b0);
    run_frame("checker", 2'd3, DW'($urandom), 1'b0);
    run_frame("ramp_bp", 2'd1, DW'($urandom), 1'b1);
    run_frame("bars_bp", 2'd2, DW'($urandom), 1'b1);

    // Back-to-back frames with enable held.
    rx.delete();
    ex.delete();
    ndone = 0;
    build_frame(3, 0);
    build_frame(3, 0);
    @(posedge clk);
    #1;
    mode   = 2'd3;
    enable = 1'b1;
    wait_done(2, 20000);
    enable = 1'b0;
    repeat (int'(GAP) + 6) @(posedge clk);
    #1;
    compare_stream("b2b");
    check("b2b_done_cnt", 32'(ndone), 32'd2);
    check("b2b_gap", 32'(gap_seen), 32'(int'(GAP) + 2));

    // Reset in the middle of the video packet, enable held throughout.
    rx.delete();
    ndone = 0;
    @(posedge clk);
    #1;
    mode   = 2'd2;
    enable = 1'b1;
    wait_rx(11 + 1000, 5000);
    mode       = 2'd0;
    flat_value = DW'(8'hA5);
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_data", 32'(dout_data), 32'd0);
    check("mid_rst_sop", 32'(dout_startofpacket), 32'd0);
    check("mid_rst_eop", 32'(dout_endofpacket), 32'd0);
    rx.delete();
    ex.delete();
    ndone = 0;
    build_frame(0, 8'hA5);
    wait_rx(20, 200);
    enable = 1'b0;
    wait_done(1, 20000);
    repeat (int'(GAP) + 6) @(posedge clk);
    #1;
    compare_stream("after_rst");
    check("after_rst_done_cnt", 32'(ndone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
